// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select and path-metric unit for an 8-state Viterbi decoder.
// Registers the survivor metrics, emits per-state decisions, the best state and normalisation events.
module viterbi_acs_pmu #(
  parameter int PM_W    = 7,
  parameter int INIT_PM = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_start,
  input  logic [31:0]     bmc_bus,
  output logic            out_valid,
  output logic [7:0]      decisions,
  output logic [2:0]      best_state,
  output logic [PM_W-1:0] best_pm,
  output logic            norm_pulse
);

  // Handshake: a step is accepted on every rising edge where in_valid is high and rst is low;
  // there is no ready, and out_valid pulses for exactly one cycle per accepted step.

  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  logic [PM_W-1:0] r_pm   [8];
  logic [PM_W-1:0] w_src  [8];
  logic [PM_W-1:0] w_c0   [8];
  logic [PM_W-1:0] w_c1   [8];
  logic [PM_W-1:0] w_new  [8];
  logic [PM_W-1:0] w_norm [8];
  logic [7:0]      w_dec;
  logic            w_all_hi;
  logic [2:0]      w_best_idx;
  logic [PM_W-1:0] w_best_val;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_src[k] = (in_valid && in_start) ? ((k == 0) ? '0 : INIT_V) : r_pm[k];
    end
  end

  // Destination j is reached from predecessors 2j mod 8 (p0) and 2j+1 mod 8 (p1).
  always_comb begin
    w_all_hi = 1'b1;
    for (int j = 0; j < 8; j++) begin
      w_c0[j]  = w_src[(2*j) % 8]     + {{(PM_W-2){1'b0}}, bmc_bus[4*j +: 2]};
      w_c1[j]  = w_src[(2*j + 1) % 8] + {{(PM_W-2){1'b0}}, bmc_bus[4*j+2 +: 2]};
      w_dec[j] = (w_c1[j] < w_c0[j]);
      w_new[j] = w_dec[j] ? w_c1[j] : w_c0[j];
      w_all_hi = w_all_hi & w_new[j][PM_W-1];
    end
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_norm[j] = w_all_hi ? {1'b0, w_new[j][PM_W-2:0]} : w_new[j];
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_best_idx = 3'd0;
    w_best_val = w_norm[0];
    for (int k = 1; k < 8; k++) begin
      if (w_norm[k] < w_best_val) begin
        w_best_idx = 3'(k);
        w_best_val = w_norm[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        r_pm[k] <= (k == 0) ? '0 : INIT_V;
      end
      out_valid  <= 1'b0;
      norm_pulse <= 1'b0;
      decisions  <= '0;
      best_state <= '0;
      best_pm    <= '0;
    end else begin
      out_valid  <= in_valid;
      norm_pulse <= in_valid & w_all_hi;
      if (in_valid) begin
        for (int k = 0; k < 8; k++) begin
          r_pm[k] <= w_norm[k];
        end
        decisions  <= w_dec;
        best_state <= w_best_idx;
        best_pm    <= w_best_val;
      end
    end
  end

endmodule
